// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch stage: decoder branch kinds, the default halt word and FSM states.
package fetch_unit_pkg;

  localparam logic [1:0] BrNoJump = 2'b00;
  localparam logic [1:0] BrBeq    = 2'b01;
  localparam logic [1:0] BrBlt    = 2'b10;

  localparam logic [31:0] HaltWordDefault = 32'h0000_0000;

  typedef enum logic [0:0] {
    StRun,
    StHalt
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: decoder branch request, ALU flags, instruction memory port and decoder output.
interface fetch_unit_if #(
  parameter int unsigned PC_WIDTH = 8
);

  logic                stall;
  logic [1:0]          branch;
  logic                branch_direction;
  logic [4:0]          branch_offset;
  logic                alu_zero;
  logic                alu_negative;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_data;
  logic [31:0]         inst;
  logic [PC_WIDTH-1:0] inst_pc;
  logic                inst_valid;
  logic                halted;

  modport master (
    input  stall, branch, branch_direction, branch_offset, alu_zero, alu_negative, imem_data,
    output imem_addr, inst, inst_pc, inst_valid, halted
  );

  modport slave (
    output stall, branch, branch_direction, branch_offset, alu_zero, alu_negative, imem_data,
    input  imem_addr, inst, inst_pc, inst_valid, halted
  );

endinterface

// File: rtl/fetch_unit_branch_resolver.sv
// Combinational branch resolution: decides whether the decoder's branch is taken and its target.
module fetch_unit_branch_resolver
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic [1:0]          branch,
  input  logic                direction,
  input  logic [4:0]          offset,
  input  logic                alu_zero,
  input  logic                alu_negative,
  input  logic                inst_valid,
  input  logic [PC_WIDTH-1:0] inst_pc,
  output logic                taken,
  output logic [PC_WIDTH-1:0] target
);

  logic [PC_WIDTH-1:0] offset_ext;

  always_comb begin
    offset_ext = PC_WIDTH'(offset);
    // A squashed slot carries stale fields, so it must never redirect.
    taken  = inst_valid & (((branch == BrBeq) & alu_zero) | ((branch == BrBlt) & alu_negative));
    target = direction ? (inst_pc - offset_ext) : (inst_pc + offset_ext);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers instruction and PC for the decoder,
// redirects on taken branches and stops on the halt word.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 8,
  parameter logic [31:0] HALT_WORD = HaltWordDefault
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  fetch_state_t        state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         inst_q;
  logic [PC_WIDTH-1:0] inst_pc_q;
  logic                inst_valid_q;
  logic                halted_q;

  logic                taken;
  logic [PC_WIDTH-1:0] target;

  fetch_unit_branch_resolver #(
    .PC_WIDTH(PC_WIDTH)
  ) u_branch_resolver (
    .branch      (bus.branch),
    .direction   (bus.branch_direction),
    .offset      (bus.branch_offset),
    .alu_zero    (bus.alu_zero),
    .alu_negative(bus.alu_negative),
    .inst_valid  (inst_valid_q),
    .inst_pc     (inst_pc_q),
    .taken       (taken),
    .target      (target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      pc_q         <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else if (!bus.stall) begin
      unique case (state_q)
        StRun: begin
          // Branch resolution has priority over a halt word on the wrong path.
          if (taken) begin
            pc_q         <= target;
            inst_valid_q <= 1'b0;
          end else if (bus.imem_data == HALT_WORD) begin
            state_q      <= StHalt;
            halted_q     <= 1'b1;
            inst_valid_q <= 1'b0;
          end else begin
            inst_q       <= bus.imem_data;
            inst_pc_q    <= pc_q;
            inst_valid_q <= 1'b1;
            pc_q         <= pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        StHalt: begin
          inst_valid_q <= 1'b0;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with hand-computed PC/instruction expectations.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [1:0] NJ  = BrNoJump;
  localparam logic [1:0] BEQ = BrBeq;
  localparam logic [1:0] BLT = BrBlt;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [1:0]  br;
    logic        dir;
    logic [4:0]  off;
    logic        z;
    logic        n;
    logic [7:0]  pc;
    logic [7:0]  ipc;
    logic        vld;
    logic        hlt;
    logic [31:0] ins;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        vecs [26];

  fetch_unit_if #(.PC_WIDTH(8)) bus ();

  fetch_unit #(
    .PC_WIDTH (8),
    .HALT_WORD(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_data = imem[bus.imem_addr];

  function automatic logic [31:0] w(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  function automatic vec_t mk(input logic rst, input logic stl, input logic [1:0] br,
                              input logic dir, input logic [4:0] off, input logic z,
                              input logic n, input logic [7:0] pc, input logic [7:0] ipc,
                              input logic vld, input logic hlt, input logic [31:0] ins);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.dir = dir; v.off = off; v.z = z; v.n = n;
    v.pc = pc; v.ipc = ipc; v.vld = vld; v.hlt = hlt; v.ins = ins;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic [1:0] br, input logic dir,
                       input logic [4:0] off, input logic z, input logic n);
    reset                = rst;
    bus.stall            = stl;
    bus.branch           = br;
    bus.branch_direction = dir;
    bus.branch_offset    = off;
    bus.alu_zero         = z;
    bus.alu_negative     = n;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] pc, input logic [7:0] ipc,
                             input logic vld, input logic hlt, input logic [31:0] ins);
    chk({tag, ".pc"},      {24'h0, bus.imem_addr}, {24'h0, pc});
    chk({tag, ".inst_pc"}, {24'h0, bus.inst_pc},   {24'h0, ipc});
    chk({tag, ".valid"},   {31'h0, bus.inst_valid}, {31'h0, vld});
    chk({tag, ".halted"},  {31'h0, bus.halted},    {31'h0, hlt});
    chk({tag, ".inst"},    bus.inst,               ins);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = w(8'(i));
    imem[6] = 32'h0000_0000;

    // Fetch at pc 6 happens only in row 7, where the taken BEQ must beat the halt word.
    vecs[0]  = mk(H, L, NJ,  L, 5'd0,  L, L, 8'd0,   8'd0,   L, L, 32'h0);
    vecs[1]  = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd1,   8'd0,   H, L, w(8'd0));
    vecs[2]  = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd2,   8'd1,   H, L, w(8'd1));
    vecs[3]  = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd3,   8'd2,   H, L, w(8'd2));
    vecs[4]  = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd4,   8'd3,   H, L, w(8'd3));
    vecs[5]  = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd5,   8'd4,   H, L, w(8'd4));
    vecs[6]  = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd6,   8'd5,   H, L, w(8'd5));
    vecs[7]  = mk(L, L, BEQ, L, 5'd3,  H, L, 8'd8,   8'd5,   L, L, w(8'd5));
    vecs[8]  = mk(L, L, BEQ, L, 5'd3,  H, L, 8'd9,   8'd8,   H, L, w(8'd8));
    vecs[9]  = mk(L, L, BEQ, H, 5'd6,  H, L, 8'd2,   8'd8,   L, L, w(8'd8));
    vecs[10] = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd3,   8'd2,   H, L, w(8'd2));
    vecs[11] = mk(L, L, BLT, H, 5'd4,  L, H, 8'd254, 8'd2,   L, L, w(8'd2));
    vecs[12] = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd255, 8'd254, H, L, w(8'd254));
    vecs[13] = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd0,   8'd255, H, L, w(8'd255));
    vecs[14] = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd1,   8'd0,   H, L, w(8'd0));
    vecs[15] = mk(L, L, BLT, L, 5'd5,  H, L, 8'd2,   8'd1,   H, L, w(8'd1));
    vecs[16] = mk(L, L, BEQ, L, 5'd5,  L, H, 8'd3,   8'd2,   H, L, w(8'd2));
    vecs[17] = mk(L, H, BEQ, L, 5'd10, H, L, 8'd3,   8'd2,   H, L, w(8'd2));
    vecs[18] = mk(L, H, BEQ, L, 5'd10, H, L, 8'd3,   8'd2,   H, L, w(8'd2));
    vecs[19] = mk(L, H, BEQ, L, 5'd10, H, L, 8'd3,   8'd2,   H, L, w(8'd2));
    vecs[20] = mk(L, L, BEQ, L, 5'd10, H, L, 8'd12,  8'd2,   L, L, w(8'd2));
    vecs[21] = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd13,  8'd12,  H, L, w(8'd12));
    vecs[22] = mk(L, L, BEQ, L, 5'd0,  H, L, 8'd12,  8'd12,  L, L, w(8'd12));
    vecs[23] = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd13,  8'd12,  H, L, w(8'd12));
    vecs[24] = mk(H, H, BEQ, L, 5'd0,  H, L, 8'd0,   8'd0,   L, L, 32'h0);
    vecs[25] = mk(L, L, NJ,  L, 5'd0,  L, L, 8'd1,   8'd0,   H, L, w(8'd0));

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].dir, vecs[i].off, vecs[i].z, vecs[i].n);
      check_state($sformatf("row%0d", i), vecs[i].pc, vecs[i].ipc, vecs[i].vld, vecs[i].hlt,
                  vecs[i].ins);
    end

    // Run sequentially into the halt word at pc 6.
    for (int i = 0; i < 5; i++) drive(L, L, NJ, L, 5'd0, L, L);
    check_state("pre_halt", 8'd6, 8'd5, H, L, w(8'd5));
    drive(L, L, NJ, L, 5'd0, L, L);
    check_state("halt", 8'd6, 8'd5, L, H, w(8'd5));

    // Halt must hold against branches and stalls for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      drive(L, (i % 2 == 1) ? H : L, BEQ, L, 5'd3, H, H);
      check_state($sformatf("halt_hold%0d", i), 8'd6, 8'd5, L, H, w(8'd5));
    end

    drive(H, L, NJ, L, 5'd0, L, L);
    check_state("halt_reset", 8'd0, 8'd0, L, L, 32'h0);
    drive(L, L, NJ, L, 5'd0, L, L);
    check_state("after_reset", 8'd1, 8'd0, H, L, w(8'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
